// File: rtl/tc_pl_acp_pkg.sv
// rtl/tc_pl_acp_pkg.sv - shared types and constants for the ACP0 write-channel arbiter
package tc_pl_acp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA
  } arb_state_t;

  localparam int ACP_IDW   = 3;
  localparam int DEF_BEATS = 16;
  localparam int DEF_TMO   = 4096;

  // Round-robin successor of requester g among n requesters.
  function automatic logic [1:0] rr_after(input logic [1:0] g, input int n);
    return (int'(g) + 1 >= n) ? 2'd0 : g + 2'd1;
  endfunction

endpackage

// File: rtl/tc_pl_rr_pick.sv
// rtl/tc_pl_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module tc_pl_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      idx,
  output logic            valid
);

  // Walk offsets from the far end so the nearest offset to ptr is written last and wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && ((int'(ptr) + k) % NREQ == j)) begin
          idx   = 2'(j);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tc_pl_acp_arb.sv
// rtl/tc_pl_acp_arb.sv - round-robin burst arbiter for the ACP0 write channel with beat-stall watchdog
module tc_pl_acp_arb
  import tc_pl_acp_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int BEATS = DEF_BEATS,
  parameter int TMO   = DEF_TMO,
  parameter int AW    = 32,
  parameter int DW    = 64
) (
  input  logic                    clk125,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_en,
  input  logic [NREQ*AW-1:0]      req_awaddr,
  input  logic [NREQ*ACP_IDW-1:0] req_awid,
  input  logic [NREQ*DW-1:0]      req_wdata,
  output logic [NREQ-1:0]         req_ack,
  output logic [NREQ-1:0]         req_wdreq,
  output logic                    acp0_tx_en,
  input  logic                    acp0_tx_rdy,
  output logic [AW-1:0]           acp0_tx_awaddr,
  output logic [ACP_IDW-1:0]      acp0_tx_awid,
  output logic [DW-1:0]           acp0_tx_wdata,
  input  logic                    acp0_tx_wdreq,
  output logic                    arb_busy,
  output logic                    arb_err,
  output logic [1:0]              arb_gnt
);

  localparam int BW = $clog2(BEATS);
  localparam int TW = $clog2(TMO);

  arb_state_t    state, state_nxt;
  logic [1:0]    rr_ptr;
  logic [1:0]    pick_idx;
  logic          pick_valid;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          grant, beat, last_beat, tmo_hit;

  tc_pl_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_en),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign grant     = (state == IDLE) && acp0_tx_rdy && pick_valid;
  assign beat      = (state == DATA) && acp0_tx_wdreq;
  assign last_beat = beat && (beat_cnt == BW'(BEATS - 1));
  assign tmo_hit   = (state == DATA) && !acp0_tx_wdreq && (tmo_cnt == TW'(TMO - 1));

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = DATA;
      DATA:    if (last_beat || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      rr_ptr         <= '0;
      arb_gnt        <= '0;
      arb_err        <= 1'b0;
      beat_cnt       <= '0;
      tmo_cnt        <= '0;
      acp0_tx_awaddr <= '0;
      acp0_tx_awid   <= '0;
    end else begin
      if (grant) begin
        arb_gnt <= pick_idx;
        for (int j = 0; j < NREQ; j++) begin
          if (pick_idx == 2'(j)) begin
            acp0_tx_awaddr <= req_awaddr[j*AW +: AW];
            acp0_tx_awid   <= req_awid[j*ACP_IDW +: ACP_IDW];
          end
        end
      end
      // Both counters saturate at their exit value; the FSM leaves DATA on that same cycle.
      if (state == ISSUE) begin
        beat_cnt <= '0;
        tmo_cnt  <= '0;
      end else if (beat) begin
        tmo_cnt <= '0;
        if (!last_beat) beat_cnt <= beat_cnt + BW'(1);
      end else if ((state == DATA) && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (last_beat || tmo_hit) rr_ptr <= rr_after(arb_gnt, NREQ);
      if (tmo_hit) arb_err <= 1'b1;
    end
  end

  assign acp0_tx_en = (state == ISSUE);
  assign arb_busy   = (state != IDLE);

  // Beat requests and data reach the granted requester only inside DATA, so stray or late beats go nowhere.
  always_comb begin
    req_ack       = '0;
    req_wdreq     = '0;
    acp0_tx_wdata = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (arb_gnt == 2'(j)) begin
        req_ack[j]   = (state == ISSUE);
        req_wdreq[j] = beat;
        if (state == DATA) acp0_tx_wdata = req_wdata[j*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_tc_pl_acp_arb.sv
// tb/tb_tc_pl_acp_arb.sv - self-checking bench for tc_pl_acp_arb against a transaction-level model
module tb_tc_pl_acp_arb;

  localparam int NREQ  = 2;
  localparam int BEATS = 16;
  localparam int TMO   = 32;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam logic [DW-1:0] WD1 = 64'hDEAD_BEEF_0000_0001;

  logic              clk125 = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_en = '0;
  logic [NREQ*AW-1:0] req_awaddr = '0;
  logic [NREQ*3-1:0] req_awid = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_ack, req_wdreq;
  logic              acp0_tx_en;
  logic              acp0_tx_rdy = 1'b0;
  logic [AW-1:0]     acp0_tx_awaddr;
  logic [2:0]        acp0_tx_awid;
  logic [DW-1:0]     acp0_tx_wdata;
  logic              acp0_tx_wdreq = 1'b0;
  logic              arb_busy, arb_err;
  logic [1:0]        arb_gnt;

  int checks = 0;
  int errors = 0;
  bit auto_drop = 1'b1;

  always #4 clk125 = ~clk125;

  tc_pl_acp_arb #(.NREQ(NREQ), .BEATS(BEATS), .TMO(TMO), .AW(AW), .DW(DW)) dut (
    .clk125         (clk125),
    .rst            (rst),
    .req_en         (req_en),
    .req_awaddr     (req_awaddr),
    .req_awid       (req_awid),
    .req_wdata      (req_wdata),
    .req_ack        (req_ack),
    .req_wdreq      (req_wdreq),
    .acp0_tx_en     (acp0_tx_en),
    .acp0_tx_rdy    (acp0_tx_rdy),
    .acp0_tx_awaddr (acp0_tx_awaddr),
    .acp0_tx_awid   (acp0_tx_awid),
    .acp0_tx_wdata  (acp0_tx_wdata),
    .acp0_tx_wdreq  (acp0_tx_wdreq),
    .arb_busy       (arb_busy),
    .arb_err        (arb_err),
    .arb_gnt        (arb_gnt)
  );

  // Transaction-level model: a pending issue, an owned burst with beat/idle tallies, a preferred next requester.
  bit          m_issue = 0, m_active = 0, m_err = 0;
  int          m_gnt = 0, m_beats = 0, m_idle = 0, m_pref = 0;
  logic [AW-1:0] m_awaddr = '0;
  logic [2:0]  m_awid = '0;

  initial begin
    forever begin
      @(posedge clk125 or negedge rst);
      if (!rst) begin
        m_issue = 0; m_active = 0; m_err = 0; m_gnt = 0;
        m_beats = 0; m_idle = 0; m_pref = 0; m_awaddr = '0; m_awid = '0;
      end else if (m_issue) begin
        m_issue = 0; m_active = 1; m_beats = 0; m_idle = 0;
      end else if (m_active) begin
        if (acp0_tx_wdreq) begin
          m_beats++; m_idle = 0;
          if (m_beats == BEATS) begin m_active = 0; m_pref = (m_gnt + 1) % NREQ; end
        end else begin
          m_idle++;
          if (m_idle == TMO) begin m_err = 1; m_active = 0; m_pref = (m_gnt + 1) % NREQ; end
        end
      end else if (acp0_tx_rdy) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_pref + k) % NREQ;
          if (req_en[c] && !m_issue) begin
            m_issue = 1; m_gnt = c;
            m_awaddr = req_awaddr[c*AW +: AW];
            m_awid = req_awid[c*3 +: 3];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      logic [NREQ-1:0] e_ack, e_wdreq;
      logic [DW-1:0]   e_wdata;
      @(negedge clk125);
      e_ack   = m_issue ? NREQ'(1 << m_gnt) : '0;
      e_wdreq = (m_active && acp0_tx_wdreq) ? NREQ'(1 << m_gnt) : '0;
      e_wdata = m_active ? req_wdata[m_gnt*DW +: DW] : '0;
      chk("m_busy", arb_busy, m_issue || m_active);
      chk("m_tx_en", acp0_tx_en, m_issue);
      chk("m_ack", req_ack, e_ack);
      chk("m_wdreq", req_wdreq, e_wdreq);
      chk("m_wdata", acp0_tx_wdata, e_wdata);
      chk("m_awaddr", acp0_tx_awaddr, m_awaddr);
      chk("m_awid", acp0_tx_awid, m_awid);
      chk("m_err", arb_err, m_err);
      chk("m_gnt", arb_gnt, m_gnt);
    end
  end

  task automatic tick();
    @(posedge clk125);
    #1;
    if (auto_drop && m_issue) req_en[m_gnt] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk125);
    #1;
    rst = 1'b0; req_en = '0; acp0_tx_wdreq = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic wait_tx_en(output int n);
    n = 0;
    while (acp0_tx_en !== 1'b1 && n < 20) begin tick(); n++; end
  endtask

  task automatic run_beats(input int n, input logic [NREQ-1:0] route);
    for (int i = 0; i < n; i++) begin
      acp0_tx_wdreq = 1'b1;
      #1;
      chk("route", req_wdreq, route);
      if (route == 2'b10) chk("wdata1", acp0_tx_wdata, WD1);
      tick();
    end
    acp0_tx_wdreq = 1'b0;
  endtask

  initial begin
    int n;
    bit seen, slow;
    int ord[4] = '{0, 1, 0, 1};
    req_wdata = {WD1, 64'h0123_4567_89AB_CDEF};
    repeat (3) @(posedge clk125);
    #1 rst = 1'b1;

    // Reset values
    do_reset();
    chk("rst_busy", arb_busy, 0);
    chk("rst_tx_en", acp0_tx_en, 0);
    chk("rst_awaddr", acp0_tx_awaddr, 0);
    chk("rst_gnt", arb_gnt, 0);
    chk("rst_err", arb_err, 0);

    // Single request
    req_awaddr[31:0] = 32'h1000_0000; req_awid[2:0] = 3'd2;
    acp0_tx_rdy = 1'b1; req_en = 2'b01;
    wait_tx_en(n);
    chk("single_latency", n, 1);
    chk("single_awaddr", acp0_tx_awaddr, 32'h1000_0000);
    chk("single_ack", req_ack, 2'b01);
    tick();
    run_beats(BEATS, 2'b01);
    chk("single_busy_end", arb_busy, 0);

    // Fairness with both requesters held
    do_reset();
    auto_drop = 1'b0; req_en = 2'b11;
    for (int b = 0; b < 4; b++) begin
      wait_tx_en(n);
      chk("fair_latency", n, 1);
      chk("fair_gnt", arb_gnt, ord[b]);
      chk("fair_ack", req_ack, (b % 2) ? 2'b10 : 2'b01);
      if (b == 3) req_en = 2'b00;
      tick();
      chk("fair_ack_pulse", req_ack, 0);
      run_beats(BEATS, (b % 2) ? 2'b10 : 2'b01);
    end
    auto_drop = 1'b1;
    chk("idle_wdata", acp0_tx_wdata, 0);

    // Backpressure
    do_reset();
    acp0_tx_rdy = 1'b0; req_awid[5:3] = 3'd5; req_en = 2'b10; seen = 0;
    repeat (50) begin tick(); if (acp0_tx_en) seen = 1; end
    chk("bp_no_tx_en", seen, 0);
    acp0_tx_rdy = 1'b1;
    wait_tx_en(n);
    chk("bp_latency", n, 1);
    chk("bp_awid", acp0_tx_awid, 3'd5);
    tick();
    run_beats(BEATS, 2'b10);

    // Watchdog timeout
    do_reset();
    req_en = 2'b01;
    wait_tx_en(n);
    tick();
    run_beats(5, 2'b01);
    n = 0;
    while (arb_err !== 1'b1 && n < 200) begin tick(); n++; end
    chk("tmo_cycles", n, TMO);
    chk("tmo_busy", arb_busy, 0);
    acp0_tx_wdreq = 1'b1;
    #1;
    chk("tmo_stray_route", req_wdreq, 0);
    tick();
    acp0_tx_wdreq = 1'b0;

    // Reset in the middle of DATA
    do_reset();
    req_en = 2'b01;
    wait_tx_en(n);
    tick();
    run_beats(7, 2'b01);
    acp0_tx_wdreq = 1'b1;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", arb_busy, 0);
    chk("mid_rst_wdreq", req_wdreq, 0);
    chk("mid_rst_wdata", acp0_tx_wdata, 0);
    chk("mid_rst_awaddr", acp0_tx_awaddr, 0);
    tick();
    rst = 1'b1; acp0_tx_wdreq = 1'b0; req_en = 2'b11;
    wait_tx_en(n);
    chk("post_rst_latency", n, 1);
    chk("post_rst_ack", req_ack, 2'b01);
    tick();
    run_beats(BEATS, 2'b01);
    chk("post_rst_busy", arb_busy, 0);

    // Randomized traffic against the model
    slow = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 300 == 0) slow = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_en[i] && $urandom_range(0, 7) == 0) begin
          req_en[i] = 1'b1;
          req_awaddr[i*AW +: AW] = $urandom;
          req_awid[i*3 +: 3] = 3'($urandom);
        end
      end
      acp0_tx_rdy   = ($urandom_range(0, 5) != 0);
      acp0_tx_wdreq = slow ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 3) != 0);
      req_wdata     = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
